// File: rtl/mem_addr_arbiter.sv
// Two-requester memory address arbiter: IDLE -> ACCESS -> ACK, all outputs registered.
// Optional macro ARB_FIXED_PRIO_EN makes A win every tie (no round-robin history kept).
module mem_addr_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [ADDR_W-1:0] addr_out,
  output logic              mem_en,
  output logic              ack_a,
  output logic              ack_b,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       pick_a;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_a = req_a;
`else
  logic last_b;
  // On a tie A wins only if B was the one served most recently.
  assign pick_a = req_a && (!req_b || last_b);
`endif

  // sel doubles as the record of the current owner, so ACK knows whom to strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      sel      <= 1'b0;
      addr_out <= '0;
      mem_en   <= 1'b0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      busy     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_b   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            state    <= ACCESS;
            gnt_a    <= pick_a;
            gnt_b    <= !pick_a;
            sel      <= pick_a;
            addr_out <= pick_a ? addr_a : addr_b;
            mem_en   <= 1'b1;
            busy     <= 1'b1;
            cnt      <= CNT_LOAD;
`ifndef ARB_FIXED_PRIO_EN
            last_b   <= !pick_a;
`endif
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state  <= ACK;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            mem_en <= 1'b0;
            ack_a  <= sel;
            ack_b  <= !sel;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          state <= IDLE;
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_addr_arbiter.sv
// Randomized and directed bench for mem_addr_arbiter against a transaction-age reference model.
// Honours ARB_FIXED_PRIO_EN the same way the design does.
module tb_mem_addr_arbiter;

  localparam int W  = 12;
  localparam int AC = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_a = 1'b0, req_b = 1'b0;
  logic [W-1:0] addr_a = '0, addr_b = '0;
  logic         gnt_a, gnt_b, sel, mem_en, ack_a, ack_b, busy;
  logic [W-1:0] addr_out;

  int errCount = 0;
  int checkCount = 0;

  // Reference model: age of the current transaction (-1 = idle), 0..AC-1 granted, AC = ack cycle.
  int           age;
  bit           ownerA;
  bit           lastB;
  logic         eSel;
  logic [W-1:0] eAddr;

  int grantsSeen, acksSeen;
  bit prevGnt;

  mem_addr_arbiter #(.ADDR_W(W), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .addr_a(addr_a), .req_b(req_b), .addr_b(addr_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .addr_out(addr_out),
    .mem_en(mem_en), .ack_a(ack_a), .ack_b(ack_b), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic [W-1:0] aa, input logic rb, input logic [W-1:0] ab);
    req_a  = ra;
    addr_a = aa;
    req_b  = rb;
    addr_b = ab;
  endtask

  function automatic void modelReset();
    age   = -1;
    ownerA = 1'b0;
    lastB = 1'b1;
    eSel  = 1'b0;
    eAddr = '0;
  endfunction

  function automatic void modelStep();
    bit winA;
    if (rst) begin
      modelReset();
      return;
    end
    if (age < 0) begin
      if (req_a || req_b) begin
        if (req_a && req_b) begin
`ifdef ARB_FIXED_PRIO_EN
          winA = 1'b1;
`else
          winA = lastB;
`endif
        end else begin
          winA = req_a;
        end
        ownerA = winA;
        lastB  = !winA;
        age    = 0;
        eSel   = winA;
        eAddr  = winA ? addr_a : addr_b;
      end
    end else if (age < AC) begin
      age++;
    end else begin
      age = -1;
    end
  endfunction

  task automatic compareAll();
    bit granted, acking;
    granted = (age >= 0) && (age < AC);
    acking  = (age == AC);
    checkOutput("gnt_a",    gnt_a,    granted && ownerA);
    checkOutput("gnt_b",    gnt_b,    granted && !ownerA);
    checkOutput("mem_en",   mem_en,   granted);
    checkOutput("ack_a",    ack_a,    acking && ownerA);
    checkOutput("ack_b",    ack_b,    acking && !ownerA);
    checkOutput("busy",     busy,     age >= 0);
    checkOutput("sel",      sel,      eSel);
    checkOutput("addr_out", addr_out, eAddr);
    checkOutput("gnt_excl", gnt_a & gnt_b, 0);
    checkOutput("ack_excl", ack_a & ack_b, 0);
    if ((gnt_a || gnt_b) && !prevGnt) grantsSeen++;
    if (ack_a || ack_b) acksSeen++;
    prevGnt = gnt_a || gnt_b;
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  // Advances to the next fresh grant; a missing grant within the budget is a failure.
  task automatic waitGrant(output bit winA);
    int budget = 20;
    while ((gnt_a || gnt_b) && budget > 0) begin cycle(); budget--; end
    while (!(gnt_a || gnt_b) && budget > 0) begin cycle(); budget--; end
    if (budget == 0) checkOutput("grant_timeout", 0, 1);
    winA = gnt_a;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bit winA;
    int memCnt, ackCnt;
    modelReset();
    prevGnt = 1'b0;
    grantsSeen = 0;
    acksSeen = 0;

    repeat (2) @(negedge clk);
    compareAll();
    rst = 1'b0;
    drain(2);

    $display("[TB] single request");
    applyStimulus(1'b1, 12'h123, 1'b0, 12'h000);
    cycle();
    checkOutput("t030_gnt_a", gnt_a, 1);
    checkOutput("t030_sel", sel, 1);
    checkOutput("t030_addr", addr_out, 12'h123);
    cycle();
    checkOutput("t030_mem_en2", mem_en, 1);
    cycle();
    checkOutput("t030_ack_a", ack_a, 1);
    applyStimulus(1'b0, 12'h123, 1'b0, 12'h000);
    cycle();
    checkOutput("t030_idle", busy, 0);
    drain(2);

    $display("[TB] tie after reset");
    rst = 1'b1;
    #1;
    modelReset();
    compareAll();
    applyStimulus(1'b1, 12'h123, 1'b1, 12'h0AB);
    @(negedge clk);
    rst = 1'b0;
    waitGrant(winA);
    checkOutput("t031_first", winA, 1);
    waitGrant(winA);
`ifdef ARB_FIXED_PRIO_EN
    checkOutput("t031_second", winA, 1);
`else
    checkOutput("t031_second", winA, 0);
    checkOutput("t031_b_addr", addr_out, 12'h0AB);
    checkOutput("t031_b_sel", sel, 0);
`endif
    waitGrant(winA);
    checkOutput("t031_third", winA, 1);
    applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);
    drain(5);

    $display("[TB] early release");
    applyStimulus(1'b0, 12'h000, 1'b1, 12'h0AB);
    waitGrant(winA);
    checkOutput("t032_owner_b", gnt_b, 1);
    memCnt = 1;
    ackCnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i == 0) req_b = 1'b0;
      if (mem_en) memCnt++;
      if (ack_b) ackCnt++;
    end
    checkOutput("t032_mem_cycles", memCnt, AC);
    checkOutput("t032_ack_count", ackCnt, 1);

    $display("[TB] address stability");
    applyStimulus(1'b1, 12'h123, 1'b0, 12'h000);
    waitGrant(winA);
    addr_a = 12'h456;
    cycle();
    checkOutput("t033_addr_hold", addr_out, 12'h123);
    req_a = 1'b0;
    drain(4);
    checkOutput("t033_idle_addr", addr_out, 12'h123);
    checkOutput("t033_idle_sel", sel, 1);

    $display("[TB] reset mid-access");
    applyStimulus(1'b1, 12'h321, 1'b0, 12'h000);
    waitGrant(winA);
    rst = 1'b1;
    #1;
    modelReset();
    compareAll();
    checkOutput("t034_gnt_cleared", gnt_a, 0);
    cycle();
    rst = 1'b0;
    cycle();
    checkOutput("t034_regrant", gnt_a, 1);
    checkOutput("t034_regrant_addr", addr_out, 12'h321);
    req_a = 1'b0;
    drain(5);

    $display("[TB] random traffic");
    grantsSeen = 0;
    acksSeen = 0;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), W'($urandom));
      cycle();
    end
    applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);
    drain(AC + 3);
    checkOutput("rand_grant_ack", acksSeen, grantsSeen);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_addr_arbiter.md
MEM_ADDR_ARBITER -- requirements
Module: mem_addr_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the address width.
REQ-002 Parameter ACCESS_CYCLES, default 2, legal 1..15, SHALL set the number of cycles a granted access holds the bus.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_a  in  1  SHALL be the request from requester A (fetch).
REQ-006 addr_a  in  ADDR_W  SHALL be the address from requester A.
REQ-007 req_b  in  1  SHALL be the request from requester B (data).
REQ-008 addr_b  in  ADDR_W  SHALL be the address from requester B.
REQ-009 gnt_a, gnt_b  out  1 each  SHALL indicate the requester that currently owns the bus.
REQ-010 sel  out  1  SHALL drive the downstream address-mux select: 1 selects A, 0 selects B.
REQ-011 addr_out  out  ADDR_W  SHALL carry the registered address of the granted requester.
REQ-012 mem_en  out  1  SHALL indicate that a memory access is in progress.
REQ-013 ack_a, ack_b  out  1 each  SHALL be single-cycle completion strobes.
REQ-014 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, ACCESS and ACK; all outputs SHALL be registered.
REQ-016 IDLE: if req_a or req_b is sampled high, the FSM SHALL pick a winner and enter ACCESS on the next edge; otherwise it SHALL stay in IDLE.
REQ-017 Entering ACCESS SHALL:
  - assert gnt of the winner and mem_en;
  - set sel to the winner;
  - latch the winner's address into addr_out;
  - load the 4-bit counter with ACCESS_CYCLES-1.
REQ-018 ACCESS SHALL decrement the counter each cycle; when the counter is 0, the next edge SHALL enter ACK.
  - Result: gnt/mem_en stay high for exactly ACCESS_CYCLES cycles.
REQ-019 ACK SHALL hold gnt/mem_en low and assert ack of the winner for exactly one cycle, then return to IDLE.
REQ-020 No arbitration SHALL occur in ACCESS or ACK.
  - Sample-to-ack latency is ACCESS_CYCLES+1 cycles.
  - Minimum spacing between grants is ACCESS_CYCLES+2 cycles.
REQ-021 Tie rule: with both requests high in IDLE, the requester not served last SHALL win (round robin); a single request SHALL always win.
REQ-022 A requester SHALL hold req high until its ack; if req drops mid-access, the access SHALL still complete and ack SHALL still pulse.
REQ-023 If req is still high in IDLE after ack, it SHALL be treated as a new request.
REQ-024 sel and addr_out SHALL hold their last granted values while idle.
REQ-025 gnt_a and gnt_b SHALL never be high together, and ack_a and ack_b SHALL never be high together.
REQ-026 Address changes during ACCESS SHALL NOT affect addr_out.

Reset
REQ-027 While rst is high, asynchronously:
  - the FSM SHALL be in IDLE and the counter SHALL be 0;
  - gnt_a, gnt_b, mem_en, ack_a, ack_b, busy, sel and addr_out SHALL be 0;
  - the last-served record SHALL be B, so A wins the first tie.
REQ-028 Reset asserted mid-ACCESS SHALL abort the access with no ack; after reset release, pending requests SHALL be arbitrated anew from IDLE.

Configuration
REQ-029 With ARB_FIXED_PRIO_EN defined, ties SHALL always be won by A and the last-served record SHALL be omitted.
  - Without ARB_FIXED_PRIO_EN, REQ-021 round robin applies.

Verification (ACCESS_CYCLES=2, ADDR_W=12)
REQ-030 Single request: req_a=1, addr_a=0x123 in IDLE at edge T. Required: gnt_a=1, sel=1, mem_en=1, addr_out=0x123 during T+1..T+2; ack_a=1 at T+3; IDLE at T+4.
REQ-031 Tie after reset: req_a=req_b=1 held. Required: A granted first; then B (addr_b=0x0AB appears on addr_out with sel=0); then A again. With ARB_FIXED_PRIO_EN defined: A every time.
REQ-032 Early release: req_b drops one cycle after gnt_b rises. Required: mem_en still high for 2 cycles and ack_b pulses once.
REQ-033 Address stability: addr_a changes 0x123->0x456 during ACCESS. Required: addr_out stays 0x123.
REQ-034 Reset mid-access: rst pulsed in the first ACCESS cycle. Required: all outputs 0 immediately with no ack; a request still pending after release is granted 1 cycle later.
REQ-035 Mutual exclusion: random requests for 10k cycles. Required: gnt_a&gnt_b==0 and ack_a&ack_b==0 throughout; every grant is followed by exactly one ack.
